// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive front end (sync, start validation, mid-bit sampling, stop/parity checks); optional parity via `UART_RX_PARITY_EN
module uart_rx_deserializer #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rx,
   input  logic                 BIST_Mode,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Data_Rdy,
   output logic                 Framing_Error,
   output logic                 Parity_Error,
   output logic                 Busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_s_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 rdy_q, rdy_d, ferr_q, ferr_d;
   logic                 tc;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d, perr_q, perr_d;
`endif

   assign tc            = (cnt_q == LAST);
   assign Rx_Data       = data_q;
   assign Data_Rdy      = rdy_q;
   assign Framing_Error = ferr_q;
   assign Busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign Parity_Error  = perr_q;
`else
   // no parity slot on the wire; the parity sense is irrelevant here
   assign Parity_Error  = 1'b0 & PARITY_ODD;
`endif

   // two-flop synchronizer on the async line, idling high out of reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= Rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // state, counters, shift register, output byte and registered strobes
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // frame sequencing: half-bit start check, then one sample per bit at mid-bit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      rdy_d   = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tc) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
               if (bit_q == BIT_LAST) state_d = PARITY;
`else
               if (bit_q == BIT_LAST) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tc) begin
               cnt_d   = '0;
               par_d   = rx_s_q;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tc) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  rdy_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_q != ((^shift_q) ^ PARITY_ODD);
`endif
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (BIST_Mode) begin
         state_d = IDLE;
         cnt_d   = '0;
         data_d  = data_q;
         rdy_d   = 1'b0;
         ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed checks of the UART receiver at 16 clocks per bit
module tb_uart_rx_deserializer;
   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NB  = 11;
`else
   localparam int NB  = 10;
`endif
   localparam int LAT = 3 + 8 + 8 * CPB + (NB - 10) * CPB + CPB;

   logic       clk = 1'b0, rst = 1'b0, Rx = 1'b1, BIST_Mode = 1'b0;
   logic [7:0] Rx_Data;
   logic       Data_Rdy, Framing_Error, Parity_Error, Busy;
   int         vectors = 0, miscompares = 0;
   int         cyc = 0, rdy_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0, bad_cnt = 0;
   int         rdy_cyc[$];
   logic [7:0] rdy_dat[$];
   int         c0;

   uart_rx_deserializer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .Rx(Rx), .BIST_Mode(BIST_Mode), .Rx_Data(Rx_Data),
      .Data_Rdy(Data_Rdy), .Framing_Error(Framing_Error), .Parity_Error(Parity_Error), .Busy(Busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (Data_Rdy) begin
         rdy_cnt++;
         rdy_cyc.push_back(cyc);
         rdy_dat.push_back(Rx_Data);
      end
      if (Framing_Error) ferr_cnt++;
      if (Parity_Error) perr_cnt++;
      if (Data_Rdy && Parity_Error) both_cnt++;
      if (Framing_Error && (Data_Rdy || Parity_Error)) bad_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic v, input int n);
      Rx = v;
      wait_n(n);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic stop, input logic par_flip);
`ifdef UART_RX_PARITY_EN
      return {stop, (^d) ^ par_flip, d, 1'b0};
`else
      return {par_flip, stop, d, 1'b0};
`endif
   endfunction

   task automatic send(input logic [10:0] bits);
      for (int i = 0; i < NB; i++) drive(bits[i], CPB);
   endtask

   initial begin
      wait_n(2);
      check("rst_busy", Busy, 0);
      check("rst_rdy", Data_Rdy, 0);
      check("rst_data", Rx_Data, 0);
      check("rst_ferr", Framing_Error, 0);
      check("rst_perr", Parity_Error, 0);
      rst = 1'b1;
      wait_n(5);
      c0 = cyc;
      send(mk(8'h55, 1'b1, 1'b0));
      wait_n(10);
      check("t1_rdy_cnt", rdy_cnt, 1);
      check("t1_data", rdy_dat[0], 8'h55);
      check("t1_latency", rdy_cyc[0] - c0, LAT);
      check("t1_ferr", ferr_cnt, 0);
      check("t1_busy", Busy, 0);
      check("t1_hold", Rx_Data, 8'h55);
      Rx = 1'b0;
      wait_n(3);
      check("t2_busy_in_start", Busy, 1);
      wait_n(1);
      Rx = 1'b1;
      wait_n(20);
      check("t2_busy", Busy, 0);
      check("t2_rdy_cnt", rdy_cnt, 1);
      check("t2_ferr", ferr_cnt, 0);
      send(mk(8'hA3, 1'b0, 1'b0));
      wait_n(40);
      check("t3_ferr", ferr_cnt, 1);
      check("t3_rdy_cnt", rdy_cnt, 1);
      check("t3_hold", Rx_Data, 8'h55);
      check("t3_busy_break", Busy, 1);
      Rx = 1'b1;
      wait_n(5);
      check("t3_busy_release", Busy, 0);
      wait_n(20);
      send(mk(8'hA3, 1'b1, 1'b0));
      send(mk(8'h3C, 1'b1, 1'b0));
      wait_n(10);
      check("t4_rdy_cnt", rdy_cnt, 3);
      check("t4_data0", rdy_dat[1], 8'hA3);
      check("t4_data1", rdy_dat[2], 8'h3C);
      check("t4_spacing", rdy_cyc[2] - rdy_cyc[1], NB * CPB);
      check("t4_ferr", ferr_cnt, 1);
      drive(1'b0, CPB);
      drive(1'b1, 4 * CPB + 8);
      rst = 1'b0;
      wait_n(2);
      check("t5_rst_busy", Busy, 0);
      check("t5_rst_data", Rx_Data, 0);
      rst = 1'b1;
      wait_n(6 * CPB);
      check("t5_no_strobe", rdy_cnt, 3);
      send(mk(8'h12, 1'b1, 1'b0));
      wait_n(10);
      check("t5_rdy_cnt", rdy_cnt, 4);
      check("t5_data", rdy_dat[3], 8'h12);
      check("t5_ferr", ferr_cnt, 1);
      Rx = 1'b0;
      wait_n(30);
      check("bist_busy_before", Busy, 1);
      BIST_Mode = 1'b1;
      wait_n(2);
      check("bist_busy", Busy, 0);
      wait_n(NB * CPB);
      Rx = 1'b1;
      wait_n(20);
      BIST_Mode = 1'b0;
      wait_n(20);
      check("bist_rdy_cnt", rdy_cnt, 4);
      check("bist_ferr", ferr_cnt, 1);
      check("bist_hold", Rx_Data, 8'h12);
`ifdef UART_RX_PARITY_EN
      send(mk(8'h07, 1'b1, 1'b1));
      wait_n(10);
      check("t6_rdy_bad", rdy_cnt, 5);
      check("t6_both", both_cnt, 1);
      check("t6_data_bad", rdy_dat[4], 8'h07);
      send(mk(8'h07, 1'b1, 1'b0));
      wait_n(10);
      check("t6_rdy_good", rdy_cnt, 6);
      check("t6_data_good", rdy_dat[5], 8'h07);
      check("t6_perr_cnt", perr_cnt, 1);
      check("t6_perr_coincident", both_cnt, perr_cnt);
`else
      check("perr_never", perr_cnt, 0);
`endif
      check("strobe_overlap", bad_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive front end that sits directly upstream of the receive FIFO. It synchronizes the asynchronous serial line, detects and validates the start bit, and samples DATA_BITS data bits (LSB first) at mid-bit. It optionally checks a parity bit and checks the stop bit. Each good byte is presented on Rx_Data with a single-cycle Data_Rdy strobe that the FIFO consumes directly.

Parameters:
DATA_BITS, 8, payload width per frame (5..9).
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); minimum 4.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when UART_RX_PARITY_EN is defined).

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
Rx  input  1  asynchronous serial line; idles high.
BIST_Mode  input  1  when high, receiver held idle and no strobes issued.
Rx_Data  output  DATA_BITS  last received byte; holds until the next good frame.
Data_Rdy  output  1  one-cycle strobe: Rx_Data valid; drives the FIFO write.
Framing_Error  output  1  one-cycle strobe: stop bit sampled low.
Parity_Error  output  1  one-cycle strobe, coincident with Data_Rdy: parity mismatch.
Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low at a clk edge): state IDLE; bit counter and cycle counter = 0; synchronizer flops = 1; Rx_Data = 0; Data_Rdy, Framing_Error, Parity_Error, and Busy = 0. Reset mid-frame aborts the frame with no strobes.
- Input sync: 2-flop synchronizer on Rx, reset to 1. All decisions use the synchronized value rx_s, which has 2 cycles of latency.
- Cycle counter width is $clog2(CLKS_PER_BIT). HALF = (CLKS_PER_BIT-1)/2, using integer division.
- IDLE: when rx_s == 0, go to START with the counter cleared.
- START: count to HALF. At HALF, if rx_s == 0 go to DATA with the counter cleared and the bit index = 0. Otherwise it is a false start: return to IDLE with no strobe.
- DATA: count to CLKS_PER_BIT-1. At terminal count, shift rx_s into the MSB of the shift register (LSB-first reception), clear the counter, and increment the bit index. After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
- PARITY (optional): at terminal count, sample the parity bit, then go to STOP.
- STOP: at terminal count (mid stop bit):
  - rx_s == 1: load Rx_Data from the shift register. Next cycle, Data_Rdy = 1 for exactly one cycle. Go to IDLE immediately, with no wait for the end of the stop bit, so back-to-back frames resync.
  - rx_s == 0: Framing_Error = 1 for one cycle. No Data_Rdy, and Rx_Data is unchanged. Go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. This covers line-break and stuck-low conditions.
- Latency: Data_Rdy asserts 1 cycle after the mid-stop sample, about 2 + (DATA_BITS+1.5)*CLKS_PER_BIT cycles after the falling start edge on Rx.
- BIST_Mode high: the FSM is forced to IDLE on the next edge, all strobes are 0, and Rx_Data is held. Deasserting BIST_Mode with the line low starts a new frame from that point.
- Strobes are never asserted together except Data_Rdy with Parity_Error.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame carries a parity bit after the data bits, and the PARITY state exists. Expected parity = (^data) ^ PARITY_ODD. On mismatch, the byte is still delivered, and Parity_Error strobes in the same cycle as Data_Rdy.
- Not defined: there is no parity bit or PARITY state, DATA goes straight to STOP, and Parity_Error is tied to 0.

Test Plan:
1. CLKS_PER_BIT=16, rst pulsed low 2 cycles, then frame 0x55 with stop=1 -> exactly one Data_Rdy pulse, Rx_Data=0x55, and no error strobes; Busy is low afterward.
2. Rx driven low for 4 clks then high (glitch shorter than HALF=7) -> FSM returns to IDLE with no Data_Rdy and no Framing_Error.
3. Frame 0xA3 with stop bit = 0, then line held low 40 clks -> one Framing_Error pulse, no Data_Rdy, Rx_Data holds its previous value, and Busy stays high until Rx returns high.
4. Back-to-back frames 0xA3 then 0x3C with no idle gap -> two Data_Rdy pulses 160 clks apart, with Rx_Data = 0xA3 and then 0x3C.
5. rst driven low during data bit 4 of frame 0xFF, released, then frame 0x12 sent -> no strobe for the aborted frame; Data_Rdy fires once with Rx_Data=0x12.
6. With UART_RX_PARITY_EN defined and PARITY_ODD=0, frame 0x07 sent with parity bit = 0 -> Data_Rdy and Parity_Error pulse in the same cycle, Rx_Data=0x07; the same frame with parity bit = 1 -> Data_Rdy only.
